// File: rtl/lsu_pkg.sv
// Shared definitions for the scpu load/store unit: RV32I funct3 size codes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/lsu_if.sv
// Bundle of the LSU's execute request, data-memory request/response and register write-back signals.
interface lsu_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [ADDR_WIDTH-1:0] req_rd;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [3:0]            mem_wmask;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;

  logic                  wb_we;
  logic [ADDR_WIDTH-1:0] wb_wa;
  logic [DATA_WIDTH-1:0] wb_wd;
  logic                  err;

  modport slave (
    input  req_valid, req_wen, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_ready, resp_valid, resp_rdata,
    output req_ready, mem_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    output wb_we, wb_wa, wb_wd, err
  );

  modport master (
    output req_valid, req_wen, req_funct3, req_addr, req_wdata, req_rd,
    output mem_ready, resp_valid, resp_rdata,
    input  req_ready, mem_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    input  wb_we, wb_wa, wb_wd, err
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and replicated data, load byte/half extraction
// with sign/zero extension, and the legality check on funct3 and address alignment.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte      = rdata[{addr_lo, 3'b000} +: 8];
    rhalf      = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    wmask      = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    illegal    = 1'b0;
    // Unsigned variants exist only for loads, so they are illegal with wen set.
    case (funct3)
      F3_B: begin
        wmask      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{rbyte[7]}}, rbyte};
      end
      F3_H: begin
        wmask      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{rhalf[15]}}, rhalf};
        illegal    = addr_lo[0];
      end
      F3_W: begin
        wmask   = 4'b1111;
        illegal = (addr_lo != 2'b00);
      end
      F3_BU: begin
        rdata_ext = {24'd0, rbyte};
        illegal   = wen;
      end
      F3_HU: begin
        rdata_ext = {16'd0, rhalf};
        illegal   = wen | addr_lo[0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: one memory op at a time, valid/ready memory request,
// single registered write-back beat for loads.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic   clk,
  input logic   rst,
  lsu_if.slave  bus
);

  state_t                state;
  logic [2:0]            op_funct3;
  logic [1:0]            op_off;
  logic                  op_wen;
  logic [ADDR_WIDTH-1:0] op_rd;

  logic [2:0]            al_funct3;
  logic [1:0]            al_off;
  logic                  al_wen;
  logic [3:0]            al_wmask;
  logic [31:0]           al_wdata_lane;
  logic [31:0]           al_rdata_ext;
  logic                  al_illegal;

  assign bus.req_ready = (state == IDLE);

  // The aligner checks the incoming request while idle and works on the latched op otherwise.
  always_comb begin
    al_funct3 = op_funct3;
    al_off    = op_off;
    al_wen    = op_wen;
    if (state == IDLE) begin
      al_funct3 = bus.req_funct3;
      al_off    = bus.req_addr[1:0];
      al_wen    = bus.req_wen;
    end
  end

  lsu_align u_align (
    .funct3     (al_funct3),
    .addr_lo    (al_off),
    .wen        (al_wen),
    .wdata      (bus.req_wdata),
    .rdata      (bus.resp_rdata),
    .wmask      (al_wmask),
    .wdata_lane (al_wdata_lane),
    .rdata_ext  (al_rdata_ext),
    .illegal    (al_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op_funct3     <= 3'd0;
      op_off        <= 2'd0;
      op_wen        <= 1'b0;
      op_rd         <= '0;
      bus.mem_valid <= 1'b0;
      bus.mem_wen   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wmask <= 4'd0;
      bus.mem_wdata <= '0;
      bus.wb_we     <= 1'b0;
      bus.wb_wa     <= '0;
      bus.wb_wd     <= '0;
      bus.err       <= 1'b0;
    end else begin
      bus.err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (al_illegal) begin
              bus.err <= 1'b1;
            end else begin
              op_funct3     <= bus.req_funct3;
              op_off        <= bus.req_addr[1:0];
              op_wen        <= bus.req_wen;
              op_rd         <= bus.req_rd;
              bus.mem_valid <= 1'b1;
              bus.mem_wen   <= bus.req_wen;
              bus.mem_addr  <= {bus.req_addr[DATA_WIDTH-1:2], 2'b00};
              bus.mem_wmask <= bus.req_wen ? al_wmask : 4'b0000;
              bus.mem_wdata <= al_wdata_lane;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            bus.mem_valid <= 1'b0;
            bus.mem_wen   <= 1'b0;
            state         <= op_wen ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (bus.resp_valid) begin
            bus.wb_wd <= al_rdata_ext;
            bus.wb_wa <= op_rd;
            bus.wb_we <= (op_rd != '0);
            state     <= WB;
          end
        end
        WB: begin
          bus.wb_we <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized ops checked
// against an arithmetic reference model of the load/store rules.
module tb_lsu;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  lsu_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  lsu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err1;
    int          err_cnt;
    bit          mv;
    int          mv_cycles;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mmask;
    logic        mwen;
    bit          stable;
    int          hs_cyc;
    int          we_cnt;
    int          we_first;
    logic [4:0]  wa;
    logic [31:0] wd;
    int          ready_cyc;
  } obs_t;

  // Reference model: sizes, legality and lane arithmetic straight from the RV32I rules.
  function automatic int op_size(bit [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_legal(bit wen, bit [2:0] f3, bit [31:0] addr);
    if (op_size(f3) == 0 || (wen && f3 > 3'd2)) return 1'b0;
    return (addr % op_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] model_load(bit [2:0] f3, bit [31:0] addr, bit [31:0] word);
    longint span, v;
    span = 64'd1 << (8 * op_size(f3));
    v    = longint'({32'd0, word} >> (8 * (addr % 4))) % span;
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_mask(bit [2:0] f3, bit [31:0] addr);
    int m;
    m = ((1 << op_size(f3)) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_lane(bit [2:0] f3, bit [31:0] word);
    longint span, mult, v;
    span = 64'd1 << (8 * op_size(f3));
    mult = ((64'd1 << 32) - 1) / (span - 1);
    v    = ({32'd0, word} % span) * mult;
    return v[31:0];
  endfunction

  // Drives one request, plays the memory (stall cycles, response delay) and records what was seen.
  task automatic run_op(input bit wen, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wdata, input bit [4:0] rd, input bit [31:0] rdata,
                        input int stall, input int rdly, output obs_t o);
    int  stall_left = stall;
    bit  hs_done    = 0;
    int  resp_at    = -1;
    o = '{err1: 1'b0, err_cnt: 0, mv: 0, mv_cycles: 0, maddr: '0, mwdata: '0, mmask: '0,
          mwen: 1'b0, stable: 1, hs_cyc: -1, we_cnt: 0, we_first: -1, wa: '0, wd: '0,
          ready_cyc: -1};
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_wen    = wen;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      if (c == 1) o.err1 = bus.err;
      if (bus.err) o.err_cnt++;
      if (bus.wb_we) begin
        o.we_cnt++;
        if (o.we_first < 0) o.we_first = c;
        o.wa = bus.wb_wa;
        o.wd = bus.wb_wd;
      end
      if (bus.mem_valid && !hs_done) begin
        if (!o.mv) begin
          o.mv = 1; o.maddr = bus.mem_addr; o.mwdata = bus.mem_wdata;
          o.mmask = bus.mem_wmask; o.mwen = bus.mem_wen;
        end else if ({o.maddr, o.mwdata, o.mmask, o.mwen} !==
                     {bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_wen}) begin
          o.stable = 0;
        end
        o.mv_cycles++;
        if (stall_left > 0) stall_left--;
        else begin
          bus.mem_ready = 1'b1; hs_done = 1; o.hs_cyc = c;
          if (!wen) resp_at = c + 1 + rdly;
        end
      end
      if (c == resp_at) begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata;
      end
      if (bus.req_ready && o.ready_cyc < 0) o.ready_cyc = c;
      if (o.ready_cyc > 0 && c > o.ready_cyc) break;
    end
    bus.mem_ready  = 1'b0;
    bus.resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.mem_valid, bus.mem_wen, bus.wb_we, bus.err} !== 5'b10000) begin
      $display("[TB] FAIL reset_ctrl: got %b, expected 10000",
               {bus.req_ready, bus.mem_valid, bus.mem_wen, bus.wb_we, bus.err});
    end else passes++;
    checks++;
    if ({bus.mem_addr, bus.mem_wmask, bus.mem_wdata, bus.wb_wa, bus.wb_wd} !== '0) begin
      $display("[TB] FAIL reset_data: addr %h mask %b wdata %h wa %0d wd %h, expected all 0",
               bus.mem_addr, bus.mem_wmask, bus.mem_wdata, bus.wb_wa, bus.wb_wd);
    end else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_byte();
    obs_t o;
    run_op(1'b0, 3'd0, 32'h1003, 32'h0, 5'd5, 32'h80FF7F01, 0, 0, o);
    checks++;
    if (o.wd !== model_load(3'd0, 32'h1003, 32'h80FF7F01))
      $display("[TB] FAIL lb_data: got %h, expected %h", o.wd, model_load(3'd0, 32'h1003, 32'h80FF7F01));
    else passes++;
    checks++;
    if ({o.maddr, o.mwen, o.wa} !== {32'h1000, 1'b0, 5'd5})
      $display("[TB] FAIL lb_req: addr %h wen %b wa %0d, expected 00001000 0 5", o.maddr, o.mwen, o.wa);
    else passes++;
    checks++;
    if ({o.we_cnt, o.we_first, o.ready_cyc} !== {32'd1, 32'd3, 32'd4})
      $display("[TB] FAIL lb_timing: we_cnt %0d we_at %0d ready_at %0d, expected 1 3 4",
               o.we_cnt, o.we_first, o.ready_cyc);
    else passes++;
    run_op(1'b0, 3'd4, 32'h1003, 32'h0, 5'd6, 32'h80FF7F01, 0, 0, o);
    checks++;
    if (o.wd !== model_load(3'd4, 32'h1003, 32'h80FF7F01))
      $display("[TB] FAIL lbu_data: got %h, expected %h", o.wd, model_load(3'd4, 32'h1003, 32'h80FF7F01));
    else passes++;
  endtask

  task automatic test_store_half();
    obs_t o;
    run_op(1'b1, 3'd1, 32'h2002, 32'h1234ABCD, 5'd3, 32'h0, 0, 0, o);
    checks++;
    if ({o.maddr, o.mmask, o.mwdata, o.mwen} !==
        {32'h2000, model_mask(3'd1, 32'h2002), model_lane(3'd1, 32'h1234ABCD), 1'b1})
      $display("[TB] FAIL sh_req: addr %h mask %b data %h wen %b, expected 00002000 %b %h 1",
               o.maddr, o.mmask, o.mwdata, o.mwen, model_mask(3'd1, 32'h2002),
               model_lane(3'd1, 32'h1234ABCD));
    else passes++;
    checks++;
    if ({o.we_cnt, o.ready_cyc} !== {32'd0, 32'd2})
      $display("[TB] FAIL sh_done: we_cnt %0d ready_at %0d, expected 0 2", o.we_cnt, o.ready_cyc);
    else passes++;
  endtask

  task automatic test_backpressure();
    obs_t o;
    run_op(1'b1, 3'd2, 32'h10, 32'hCAFEF00D, 5'd0, 32'h0, 3, 0, o);
    checks++;
    if ({o.mv_cycles, o.stable, o.hs_cyc, o.ready_cyc} !== {32'd4, 1'b1, 32'd4, 32'd5})
      $display("[TB] FAIL bp_hold: valid_cycles %0d stable %b hs_at %0d ready_at %0d, expected 4 1 4 5",
               o.mv_cycles, o.stable, o.hs_cyc, o.ready_cyc);
    else passes++;
    checks++;
    if ({o.maddr, o.mwdata, o.mmask} !== {32'h10, 32'hCAFEF00D, 4'hF})
      $display("[TB] FAIL bp_req: addr %h data %h mask %b, expected 00000010 cafef00d 1111",
               o.maddr, o.mwdata, o.mmask);
    else passes++;
  endtask

  task automatic test_errors();
    obs_t o;
    bit [2:0] f3s [4] = '{3'd2, 3'd3, 3'd4, 3'd1};
    bit       wens[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bit [31:0] adr[4] = '{32'h1001, 32'h1000, 32'h1000, 32'h2003};
    for (int i = 0; i < 4; i++) begin
      run_op(wens[i], f3s[i], adr[i], 32'h55, 5'd4, 32'h0, 0, 0, o);
      checks++;
      if ({o.err1, o.err_cnt, o.mv, o.ready_cyc, o.we_cnt} !== {1'b1, 32'd1, 1'b0, 32'd1, 32'd0})
        $display("[TB] FAIL err_%0d: err %b pulses %0d mem_valid %b ready_at %0d we %0d, expected 1 1 0 1 0",
                 i, o.err1, o.err_cnt, o.mv, o.ready_cyc, o.we_cnt);
      else passes++;
    end
  endtask

  task automatic test_load_x0();
    obs_t o;
    run_op(1'b0, 3'd2, 32'h40, 32'h0, 5'd0, 32'h12345678, 0, 0, o);
    checks++;
    if ({o.mv, o.hs_cyc, o.we_cnt, o.ready_cyc} !== {1'b1, 32'd1, 32'd0, 32'd4})
      $display("[TB] FAIL x0_load: mem_valid %b hs_at %0d we %0d ready_at %0d, expected 1 1 0 4",
               o.mv, o.hs_cyc, o.we_cnt, o.ready_cyc);
    else passes++;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   we = 0;
    // Reset while a store is waiting on mem_ready.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h100; bus.req_wdata = 32'h77; bus.req_rd = 5'd1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_valid, bus.mem_addr, bus.req_ready} !== {1'b0, 32'h0, 1'b1})
      $display("[TB] FAIL rst_req: mem_valid %b addr %h ready %b, expected 0 0 1",
               bus.mem_valid, bus.mem_addr, bus.req_ready);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    // Reset while a load waits for its response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h80; bus.req_rd = 5'd7;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.mem_valid !== 1'b1)
      $display("[TB] FAIL rst_load_req: mem_valid %b, expected 1", bus.mem_valid);
    else passes++;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.mem_valid, bus.mem_wen, bus.wb_we, bus.err, bus.mem_addr, bus.wb_wd} !==
        {5'b10000, 32'h0, 32'h0})
      $display("[TB] FAIL rst_wait: ctrl %b addr %h wd %h, expected 10000 0 0",
               {bus.req_ready, bus.mem_valid, bus.mem_wen, bus.wb_we, bus.err}, bus.mem_addr, bus.wb_wd);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.resp_valid = 1'b1; bus.resp_rdata = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge clk);
      bus.resp_valid = 1'b0;
      if (bus.wb_we) we++;
    end
    checks++;
    if (we !== 0) $display("[TB] FAIL rst_stray: wb_we cycles %0d, expected 0", we);
    else passes++;
    run_op(1'b0, 3'd5, 32'h86, 32'h0, 5'd9, 32'hBEEF1234, 0, 1, o);
    checks++;
    if ({o.we_cnt, o.wa, o.wd} !== {32'd1, 5'd9, model_load(3'd5, 32'h86, 32'hBEEF1234)})
      $display("[TB] FAIL rst_after: we %0d wa %0d wd %h, expected 1 9 %h",
               o.we_cnt, o.wa, o.wd, model_load(3'd5, 32'h86, 32'hBEEF1234));
    else passes++;
  endtask

  task automatic test_random();
    obs_t o;
    for (int i = 0; i < 40; i++) begin
      bit        wen   = 1'($urandom_range(0, 1));
      bit [2:0]  f3    = wen ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      bit [31:0] addr  = $urandom;
      bit [31:0] wdata = $urandom;
      bit [31:0] rdata = $urandom;
      bit [4:0]  rd    = 5'($urandom_range(0, 31));
      int        stall = $urandom_range(0, 2);
      int        rdly  = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      run_op(wen, f3, addr, wdata, rd, rdata, stall, rdly, o);
      checks++;
      if (o.err_cnt !== int'(!model_legal(wen, f3, addr)))
        $display("[TB] FAIL rnd_err[%0d]: pulses %0d, expected %0d", i, o.err_cnt,
                 int'(!model_legal(wen, f3, addr)));
      else passes++;
      if (model_legal(wen, f3, addr)) begin
        checks++;
        if ({o.maddr, o.mwen, o.mv_cycles} !== {addr & 32'hFFFFFFFC, wen, stall + 1})
          $display("[TB] FAIL rnd_req[%0d]: addr %h wen %b valid_cycles %0d, expected %h %b %0d",
                   i, o.maddr, o.mwen, o.mv_cycles, addr & 32'hFFFFFFFC, wen, stall + 1);
        else passes++;
        if (wen) begin
          checks++;
          if ({o.mmask, o.mwdata, o.we_cnt, o.ready_cyc} !==
              {model_mask(f3, addr), model_lane(f3, wdata), 32'd0, stall + 2})
            $display("[TB] FAIL rnd_st[%0d]: mask %b data %h we %0d ready_at %0d, expected %b %h 0 %0d",
                     i, o.mmask, o.mwdata, o.we_cnt, o.ready_cyc, model_mask(f3, addr),
                     model_lane(f3, wdata), stall + 2);
          else passes++;
        end else begin
          checks++;
          if ({o.we_cnt, o.ready_cyc} !== {int'(rd != 0), stall + rdly + 4})
            $display("[TB] FAIL rnd_ld_t[%0d]: we %0d ready_at %0d, expected %0d %0d",
                     i, o.we_cnt, o.ready_cyc, int'(rd != 0), stall + rdly + 4);
          else passes++;
          if (rd != 0) begin
            checks++;
            if ({o.wa, o.wd} !== {rd, model_load(f3, addr, rdata)})
              $display("[TB] FAIL rnd_ld_d[%0d]: wa %0d wd %h, expected %0d %h",
                       i, o.wa, o.wd, rd, model_load(f3, addr, rdata));
            else passes++;
          end
        end
      end
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_rd     = '0;
    bus.mem_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    test_reset();
    test_load_byte();
    test_store_half();
    test_backpressure();
    test_errors();
    test_load_x0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lsu.md
# lsu

Multi-cycle load/store unit feeding the register-file write port in the scpu core. Accepts one memory instruction at a time from execute and drives a valid/ready data-memory request. For loads, it aligns and extends the returned word, then presents exactly one write-back beat on `wb_we/wb_wa/wb_wd`, which connect directly to the register file's `we/wa/wd`.

## Interface
- `ADDR_WIDTH`, 5: register index width.
- `DATA_WIDTH`, 32: data and address width. Only 32 is supported.
- `clk`  in  1  clock. All state is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  execute offers an operation.
- `req_ready`  out  1  LSU can accept an operation.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: LB/LH/LW/LBU/LHU, SB/SH/SW.
- `req_addr`  in  DATA_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data (rs2).
- `req_rd`  in  ADDR_WIDTH  load destination register.
- `mem_valid`  out  1  memory request valid.
- `mem_ready`  in  1  memory accepts the request.
- `mem_addr`  out  DATA_WIDTH  word address: `req_addr` with bits [1:0] forced to 0.
- `mem_wen`  out  1  store request.
- `mem_wmask`  out  4  byte enables.
- `mem_wdata`  out  DATA_WIDTH  lane-replicated store data.
- `resp_valid`  in  1  load data valid. Single cycle.
- `resp_rdata`  in  DATA_WIDTH  load word.
- `wb_we`, `wb_wa`, `wb_wd`  out  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port.
- `err`  out  1  one-cycle pulse: misaligned access or illegal funct3.

## Operation
FSM states: IDLE, REQ, WAIT, WB.
- **IDLE**
  - `req_ready=1`.
  - On `req_valid`, latch `wen/funct3/addr/wdata/rd`.
  - If the access is illegal, pulse `err` next cycle and stay in IDLE. No memory access is made.
  - Otherwise go to REQ.
- **Illegal access** means any of:
  - H access with `addr[0]=1`.
  - W access with `addr[1:0]≠0`.
  - funct3 ∉ {000,001,010,100,101} for loads.
  - funct3 ∉ {000,001,010} for stores.
- **REQ**
  - `mem_valid=1`.
  - Address, mask, data and `wen` stay stable until `mem_ready`.
  - On the handshake: a store goes to IDLE (the store is complete); a load goes to WAIT.
- **WAIT**
  - Hold until `resp_valid`.
  - Extract the addressed byte/half from `resp_rdata >> 8*addr[1:0]`.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Register the result into `wb_wd`, then go to WB.
- **WB**
  - `wb_we=1` for exactly one cycle, `wb_wa=rd`.
  - If `rd==0`, `wb_we` stays 0.
  - Then go to IDLE.
- **Store mask/data**
  - SB: `wmask = 4'b0001<<addr[1:0]`, data = byte ×4.
  - SH: `wmask` = 0011 (`addr[1]=0`) or 1100, data = half ×2.
  - SW: `wmask` = 1111.
- **Stray responses:** `resp_valid` outside WAIT is ignored.
- **Reset**
  - `rst` forces IDLE at any time.
  - `mem_valid`, `wb_we` and `err` drop immediately.
  - An in-flight response arriving after reset is ignored.

## Timing
- **Reset values:**
  - `req_ready=1`.
  - `mem_valid`, `mem_wen`, `wb_we`, `err` = 0.
  - `mem_addr`, `mem_wmask`, `mem_wdata`, `wb_wa`, `wb_wd` = 0.
- **Load, zero wait:** accepted at cycle T; `mem_valid` at T+1 (ready same cycle); `resp_valid` at T+2; `wb_we` at T+3; `req_ready` at T+4.
- **Store, zero wait:** accepted at T; handshake at T+1; `req_ready` at T+2.
- **Error:** `err` at T+1; `req_ready` stays 1 throughout.
- `mem_valid` is never withdrawn before `mem_ready`, except by reset.
- `resp_valid` in the same cycle as the `mem_ready` handshake is not allowed. Memory responds at least one cycle after the handshake.
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` or `resp_*` to any output.

## Structure
- Shared package `lsu_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - State encoding for IDLE/REQ/WAIT/WB.
- One combinational sub-module, `lsu_align`. It takes `funct3`, `addr[1:0]`, `wdata`, `rdata` and produces `wmask`, `wdata_lane`, `rdata_ext`, `illegal`.
- The FSM and registers stay in `lsu`.

## Test plan
- **Load byte, signed and unsigned:** `resp_rdata=0x80FF7F01`, LB at `addr=0x1003` → `wb_wd=0xFFFFFF80`, `wb_we` one cycle. LBU at `addr=0x1003` → `0x00000080`.
- **Store halfword:** SH with `addr=0x2002`, `wdata=0x1234ABCD` → `mem_addr=0x2000`, `wmask=1100`, `mem_wdata=0xABCDABCD`, no `wb_we`.
- **Backpressure on a store:** `mem_ready` held low 3 cycles on SW to `0x10` → `mem_valid`, `mem_addr`, `mem_wdata` stable for 4 cycles; `req_ready` low until the handshake +1.
- **Misaligned access:**
  - LW at `0x1001` → `err` pulse, no `mem_valid`.
  - Illegal load funct3 011 → `err`.
- **Load to x0:** LW `rd=0` → full handshake, `wb_we` stays 0.
- **Reset mid-operation:** `rst` asserted during WAIT → outputs at reset values immediately. A later `resp_valid` → no `wb_we`, and the next request is accepted normally.
